ghost_motion_ctrl: RTL and testbench

GHOST_MOTION_CTRL -- requirements
Module: ghost_motion_ctrl

---
 rtl/ghost_motion_pkg.sv | 45 ++++
 rtl/ghost_motion_ctrl_if.sv | 26 ++
 rtl/ghost_axis_limit.sv | 33 +++
 rtl/ghost_motion_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ghost_motion_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ghost_motion_pkg.sv
// Shared types, default geometry constants and small arithmetic helpers
// for the ghost motion controller.
package ghost_motion_pkg;

    localparam int FP_SHIFT_DFLT = 6;
    localparam int SCREEN_W_DFLT = 640;
    localparam int SCREEN_H_DFLT = 480;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StWaitEof,
        StPosChange,
        StLimits
    } state_e;

    // 2'b11 is decoded as freeze alongside ModeFreeze.
    typedef enum logic [1:0] {
        ModeBounce = 2'b00,
        ModeChase  = 2'b01,
        ModeFreeze = 2'b10
    } mode_e;

    function automatic logic signed [31:0] sat_speed(input logic signed [31:0] v,
                                                     input int lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

    function automatic logic signed [31:0] chase_speed(input logic signed [31:0] tgt,
                                                       input logic signed [31:0] pos,
                                                       input int mag);
        if (tgt > pos) begin
            return mag;
        end else if (tgt < pos) begin
            return -mag;
        end
        return 0;
    endfunction

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// Frame/collision inputs and position/status outputs of the ghost motion controller.
interface ghost_motion_ctrl_if;

    logic               startOfFrame;
    logic [1:0]         mode;
    logic signed [10:0] targetX;
    logic signed [10:0] targetY;
    logic               respawn;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               wallHit;
    logic               frameDone;

    modport master (
        output startOfFrame, mode, targetX, targetY, respawn, collision, HitEdgeCode,
        input  topLeftX, topLeftY, wallHit, frameDone
    );

    modport slave (
        input  startOfFrame, mode, targetX, targetY, respawn, collision, HitEdgeCode,
        output topLeftX, topLeftY, wallHit, frameDone
    );

endinterface

// File: rtl/ghost_axis_limit.sv
// One axis of screen-limit handling: clamps a fixed-point position into
// [POS_MIN, POS_MAX] and reflects the speed when it was heading outward.
module ghost_axis_limit #(
    parameter int POS_MIN = 128,
    parameter int POS_MAX = 36672
) (
    input  logic signed [31:0] i_pos,
    input  logic signed [31:0] i_spd,
    output logic signed [31:0] o_pos,
    output logic signed [31:0] o_spd,
    output logic               o_hit
);

    always_comb begin
        o_pos = i_pos;
        o_spd = i_spd;
        o_hit = 1'b0;
        if (i_pos < POS_MIN) begin
            o_pos = POS_MIN;
            if (i_spd < 0) begin
                o_spd = -i_spd;
                o_hit = 1'b1;
            end
        end else if (i_pos > POS_MAX) begin
            o_pos = POS_MAX;
            if (i_spd > 0) begin
                o_spd = -i_spd;
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Per-frame ghost motion: bounce/chase/freeze position update, edge collision
// reflection and screen clamping, with registered pixel outputs.
module ghost_motion_ctrl
    import ghost_motion_pkg::*;
#(
    parameter int INIT_X    = 100,
    parameter int INIT_Y    = 100,
    parameter int INIT_XSPD = 40,
    parameter int INIT_YSPD = 20,
    parameter int Y_ACCEL   = 0,
    parameter int MAX_SPEED = 400,
    parameter int FP_SHIFT  = FP_SHIFT_DFLT,
    parameter int OBJ_W     = 64,
    parameter int OBJ_H     = 64,
    parameter int SCREEN_W  = SCREEN_W_DFLT,
    parameter int SCREEN_H  = SCREEN_H_DFLT,
    parameter int MARGIN    = 2
) (
    input logic              clk,
    input logic              resetN,
    ghost_motion_ctrl_if.slave io_bus
);

    localparam int XPOS0    = INIT_X <<< FP_SHIFT;
    localparam int YPOS0    = INIT_Y <<< FP_SHIFT;
    localparam int X_MIN    = MARGIN <<< FP_SHIFT;
    localparam int Y_MIN    = MARGIN <<< FP_SHIFT;
    localparam int X_MAX    = (SCREEN_W - 1 - MARGIN - OBJ_W) <<< FP_SHIFT;
    localparam int Y_MAX    = (SCREEN_H - 1 - MARGIN - OBJ_H) <<< FP_SHIFT;
    localparam int XSPD_MAG = (INIT_XSPD < 0) ? -INIT_XSPD : INIT_XSPD;
    localparam int YSPD_MAG = (INIT_YSPD < 0) ? -INIT_YSPD : INIT_YSPD;
    localparam logic signed [10:0] TLX0 = 11'(INIT_X);
    localparam logic signed [10:0] TLY0 = 11'(INIT_Y);

    state_e             r_state, w_state_nxt;
    logic signed [31:0] r_xpos, r_ypos, r_xspd, r_yspd;
    logic signed [31:0] w_xpos_nxt, w_ypos_nxt, w_xspd_nxt, w_yspd_nxt;
    logic signed [10:0] r_tlx, r_tly, w_tlx_nxt, w_tly_nxt;
    logic               r_wall_hit, r_frame_done, w_wall_hit_nxt, w_frame_done_nxt;
    logic signed [31:0] w_xlim_pos, w_ylim_pos, w_xlim_spd, w_ylim_spd;
    logic               w_xhit, w_yhit;
    logic signed [31:0] w_tgt_x_fp, w_tgt_y_fp;

    assign w_tgt_x_fp = {{21{io_bus.targetX[10]}}, io_bus.targetX} <<< FP_SHIFT;
    assign w_tgt_y_fp = {{21{io_bus.targetY[10]}}, io_bus.targetY} <<< FP_SHIFT;

    ghost_axis_limit #(
        .POS_MIN(X_MIN),
        .POS_MAX(X_MAX)
    ) u_x_limit (
        .i_pos(r_xpos),
        .i_spd(r_xspd),
        .o_pos(w_xlim_pos),
        .o_spd(w_xlim_spd),
        .o_hit(w_xhit)
    );

    ghost_axis_limit #(
        .POS_MIN(Y_MIN),
        .POS_MAX(Y_MAX)
    ) u_y_limit (
        .i_pos(r_ypos),
        .i_spd(r_yspd),
        .o_pos(w_ylim_pos),
        .o_spd(w_ylim_spd),
        .o_hit(w_yhit)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:      if (io_bus.startOfFrame) w_state_nxt = StMove;
            StMove: begin
                if (io_bus.startOfFrame) begin
                    w_state_nxt = StPosChange;
                end else if (io_bus.collision) begin
                    w_state_nxt = StWaitEof;
                end
            end
            StWaitEof:   if (io_bus.startOfFrame) w_state_nxt = StPosChange;
            StPosChange: w_state_nxt = StLimits;
            StLimits:    w_state_nxt = StMove;
            default:     w_state_nxt = StIdle;
        endcase
        if (io_bus.respawn) begin
            w_state_nxt = StIdle;
        end
    end

    always_comb begin
        w_xpos_nxt       = r_xpos;
        w_ypos_nxt       = r_ypos;
        w_xspd_nxt       = r_xspd;
        w_yspd_nxt       = r_yspd;
        w_tlx_nxt        = r_tlx;
        w_tly_nxt        = r_tly;
        w_wall_hit_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (io_bus.respawn || r_state == StIdle) begin
            w_xpos_nxt = XPOS0;
            w_ypos_nxt = YPOS0;
            w_xspd_nxt = INIT_XSPD;
            w_yspd_nxt = INIT_YSPD;
            w_tlx_nxt  = TLX0;
            w_tly_nxt  = TLY0;
        end else begin
            case (r_state)
                StMove: begin
                    // Only reflect when the speed points into the touched edge.
                    if (io_bus.collision) begin
                        if (io_bus.HitEdgeCode[2] && r_yspd < 0) begin
                            w_yspd_nxt = -r_yspd;
                        end else if (io_bus.HitEdgeCode[0] && r_yspd > 0) begin
                            w_yspd_nxt = -r_yspd;
                        end
                        if (io_bus.HitEdgeCode[3] && r_xspd < 0) begin
                            w_xspd_nxt = -r_xspd;
                        end else if (io_bus.HitEdgeCode[1] && r_xspd > 0) begin
                            w_xspd_nxt = -r_xspd;
                        end
                    end
                end
                StPosChange: begin
                    case (io_bus.mode)
                        ModeBounce: begin
                            w_xpos_nxt = r_xpos + r_xspd;
                            w_ypos_nxt = r_ypos + r_yspd;
                            w_yspd_nxt = sat_speed(r_yspd + Y_ACCEL, MAX_SPEED);
                        end
                        ModeChase: begin
                            w_xspd_nxt = chase_speed(w_tgt_x_fp, r_xpos, XSPD_MAG);
                            w_yspd_nxt = chase_speed(w_tgt_y_fp, r_ypos, YSPD_MAG);
                            w_xpos_nxt = r_xpos + w_xspd_nxt;
                            w_ypos_nxt = r_ypos + w_yspd_nxt;
                        end
                        default: ;
                    endcase
                end
                StLimits: begin
                    w_xpos_nxt       = w_xlim_pos;
                    w_ypos_nxt       = w_ylim_pos;
                    w_xspd_nxt       = w_xlim_spd;
                    w_yspd_nxt       = w_ylim_spd;
                    w_tlx_nxt        = 11'(w_xlim_pos >>> FP_SHIFT);
                    w_tly_nxt        = 11'(w_ylim_pos >>> FP_SHIFT);
                    w_wall_hit_nxt   = w_xhit | w_yhit;
                    w_frame_done_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= StIdle;
            r_xpos       <= XPOS0;
            r_ypos       <= YPOS0;
            r_xspd       <= INIT_XSPD;
            r_yspd       <= INIT_YSPD;
            r_tlx        <= TLX0;
            r_tly        <= TLY0;
            r_wall_hit   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_xpos       <= w_xpos_nxt;
            r_ypos       <= w_ypos_nxt;
            r_xspd       <= w_xspd_nxt;
            r_yspd       <= w_yspd_nxt;
            r_tlx        <= w_tlx_nxt;
            r_tly        <= w_tly_nxt;
            r_wall_hit   <= w_wall_hit_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign io_bus.topLeftX  = r_tlx;
    assign io_bus.topLeftY  = r_tly;
    assign io_bus.wallHit   = r_wall_hit;
    assign io_bus.frameDone = r_frame_done;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Bench for ghost_motion_ctrl: vector table, corner sequences and a randomized
// run against a frame-level reference model.
module tb_ghost_motion_ctrl;
    import ghost_motion_pkg::*;

    localparam int X_MIN = 128;
    localparam int X_MAX = 36672;
    localparam int Y_MIN = 128;
    localparam int Y_MAX = 26432;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    ghost_motion_ctrl_if bus_d ();
    ghost_motion_ctrl_if bus_e ();
    ghost_motion_ctrl_if bus_a ();

    ghost_motion_ctrl u_dut (.clk(clk), .resetN(resetN), .io_bus(bus_d));
    ghost_motion_ctrl #(.INIT_X(573), .INIT_Y(413)) u_edge (
        .clk(clk), .resetN(resetN), .io_bus(bus_e));
    ghost_motion_ctrl #(.Y_ACCEL(100)) u_acc (.clk(clk), .resetN(resetN), .io_bus(bus_a));

    typedef struct {
        logic [1:0] mode;
        int         tx;
        int         ty;
        logic       col;
        logic [3:0] code;
        int         xfp;
        int         yfp;
        int         xspd;
        int         yspd;
    } vec_t;

    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   px, py, vx, vy, hit, gap, m, tx, ty;
    bit   in_idle, cdone, col;
    logic [3:0] code;
    int   acc_spd[5] = '{120, 220, 320, 400, 400};
    int   acc_pos[5] = '{6420, 6540, 6760, 7080, 7480};

    always @(negedge clk) if (bus_d.frameDone) fd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int tl(input int fp);
        logic signed [10:0] t;
        t = 11'(fp >>> 6);
        return int'(t);
    endfunction

    // One frame on u_dut: optional collision cycle, startOfFrame, then the two update cycles.
    task automatic frame_d(input logic [1:0] md, input int tgx, input int tgy,
                           input logic c, input logic [3:0] cd);
        bus_d.mode    = md;
        bus_d.targetX = 11'(tgx);
        bus_d.targetY = 11'(tgy);
        if (c) begin
            bus_d.collision   = 1'b1;
            bus_d.HitEdgeCode = cd;
            tick();
            bus_d.collision = 1'b0;
        end
        bus_d.startOfFrame = 1'b1;
        tick();
        bus_d.startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic model_col(input logic [3:0] cd);
        if (cd[2] && vy < 0) vy = -vy;
        else if (cd[0] && vy > 0) vy = -vy;
        if (cd[3] && vx < 0) vx = -vx;
        else if (cd[1] && vx > 0) vx = -vx;
    endtask

    task automatic model_frame(input int md, input int tgx, input int tgy);
        if (md == 0) begin
            px += vx;
            py += vy;
        end else if (md == 1) begin
            vx = (tgx * 64 > px) ? 40 : ((tgx * 64 < px) ? -40 : 0);
            vy = (tgy * 64 > py) ? 20 : ((tgy * 64 < py) ? -20 : 0);
            px += vx;
            py += vy;
        end
        hit = 0;
        if (px < X_MIN) begin px = X_MIN; if (vx < 0) begin vx = -vx; hit = 1; end end
        else if (px > X_MAX) begin px = X_MAX; if (vx > 0) begin vx = -vx; hit = 1; end end
        if (py < Y_MIN) begin py = Y_MIN; if (vy < 0) begin vy = -vy; hit = 1; end end
        else if (py > Y_MAX) begin py = Y_MAX; if (vy > 0) begin vy = -vy; hit = 1; end end
    endtask

    task automatic clear_d();
        bus_d.startOfFrame = 1'b0;
        bus_d.collision    = 1'b0;
        bus_d.respawn      = 1'b0;
        bus_d.HitEdgeCode  = 4'h0;
        bus_d.mode         = 2'b00;
        bus_d.targetX      = '0;
        bus_d.targetY      = '0;
    endtask

    initial begin
        tbl[0]  = '{2'd0, 0, 0, 1'b0, 4'b0000, 6440, 6420, 40, 20};
        tbl[1]  = '{2'd0, 0, 0, 1'b0, 4'b0000, 6480, 6440, 40, 20};
        tbl[2]  = '{2'd0, 0, 0, 1'b0, 4'b0000, 6520, 6460, 40, 20};
        tbl[3]  = '{2'd0, 0, 0, 1'b1, 4'b0010, 6480, 6480, -40, 20};
        tbl[4]  = '{2'd0, 0, 0, 1'b1, 4'b0001, 6440, 6460, -40, -20};
        tbl[5]  = '{2'd0, 0, 0, 1'b1, 4'b0010, 6400, 6440, -40, -20};
        tbl[6]  = '{2'd2, 0, 0, 1'b1, 4'b1100, 6400, 6440, 40, 20};
        tbl[7]  = '{2'd3, 0, 0, 1'b0, 4'b0000, 6400, 6440, 40, 20};
        tbl[8]  = '{2'd1, 50, 100, 1'b0, 4'b0000, 6360, 6420, -40, -20};
        tbl[9]  = '{2'd1, 300, 300, 1'b0, 4'b0000, 6400, 6440, 40, 20};
        tbl[10] = '{2'd1, 100, 100, 1'b0, 4'b0000, 6400, 6420, 0, -20};
        tbl[11] = '{2'd0, 0, 0, 1'b0, 4'b0000, 6400, 6400, 0, -20};

        clear_d();
        bus_e.startOfFrame = 1'b0; bus_e.collision = 1'b0; bus_e.respawn = 1'b0;
        bus_e.HitEdgeCode = 4'h0; bus_e.mode = 2'b00; bus_e.targetX = '0; bus_e.targetY = '0;
        bus_a.startOfFrame = 1'b0; bus_a.collision = 1'b0; bus_a.respawn = 1'b0;
        bus_a.HitEdgeCode = 4'h0; bus_a.mode = 2'b00; bus_a.targetX = '0; bus_a.targetY = '0;
        resetN = 1'b0;
        repeat (3) tick();
        check("rst_tlx", int'(bus_d.topLeftX), 100);
        check("rst_tly", int'(bus_d.topLeftY), 100);
        check("rst_xfp", u_dut.r_xpos, 6400);
        check("rst_xspd", u_dut.r_xspd, 40);
        check("rst_yspd", u_dut.r_yspd, 20);
        check("rst_flags", {bus_d.wallHit, bus_d.frameDone}, 0);
        check("rst_state", int'(u_dut.r_state), int'(StIdle));
        check("rst_edge_tlx", int'(bus_e.topLeftX), 573);
        resetN = 1'b1;
        tick();

        // Vector table: first startOfFrame only leaves IDLE.
        bus_d.startOfFrame = 1'b1;
        tick();
        bus_d.startOfFrame = 1'b0;
        check("idle_to_move", int'(u_dut.r_state), int'(StMove));
        for (int i = 0; i < 12; i++) begin
            frame_d(tbl[i].mode, tbl[i].tx, tbl[i].ty, tbl[i].col, tbl[i].code);
            check($sformatf("tbl%0d_xfp", i), u_dut.r_xpos, tbl[i].xfp);
            check($sformatf("tbl%0d_yfp", i), u_dut.r_ypos, tbl[i].yfp);
            check($sformatf("tbl%0d_xspd", i), u_dut.r_xspd, tbl[i].xspd);
            check($sformatf("tbl%0d_yspd", i), u_dut.r_yspd, tbl[i].yspd);
            check($sformatf("tbl%0d_tlx", i), int'(bus_d.topLeftX), tl(tbl[i].xfp));
            check($sformatf("tbl%0d_tly", i), int'(bus_d.topLeftY), tl(tbl[i].yfp));
            check($sformatf("tbl%0d_done", i), int'(bus_d.frameDone), 1);
            check($sformatf("tbl%0d_wall", i), int'(bus_d.wallHit), 0);
            tick();
            check($sformatf("tbl%0d_done_clr", i), int'(bus_d.frameDone), 0);
            if (i == 2) check("three_frame_done", fd_cnt, 3);
        end

        // One collision per frame, then collision coinciding with startOfFrame.
        bus_d.respawn = 1'b1;
        tick();
        bus_d.respawn = 1'b0;
        bus_d.startOfFrame = 1'b1;
        tick();
        bus_d.startOfFrame = 1'b0;
        bus_d.collision = 1'b1;
        bus_d.HitEdgeCode = 4'b0010;
        tick();
        check("col1_xspd", u_dut.r_xspd, -40);
        check("col1_state", int'(u_dut.r_state), int'(StWaitEof));
        bus_d.HitEdgeCode = 4'b1000;
        tick();
        bus_d.collision = 1'b0;
        check("col2_ignored", u_dut.r_xspd, -40);
        frame_d(2'd0, 0, 0, 1'b0, 4'h0);
        check("col_frame_xfp", u_dut.r_xpos, 6360);
        tick();
        bus_d.startOfFrame = 1'b1;
        bus_d.collision = 1'b1;
        bus_d.HitEdgeCode = 4'b1000;
        tick();
        clear_d();
        check("sof_col_state", int'(u_dut.r_state), int'(StPosChange));
        check("sof_col_xspd", u_dut.r_xspd, 40);
        tick();
        tick();
        check("sof_col_xfp", u_dut.r_xpos, 6400);
        tick();

        // respawn while waiting for end of frame.
        bus_d.collision = 1'b1;
        bus_d.HitEdgeCode = 4'b0001;
        tick();
        bus_d.collision = 1'b0;
        check("wait_state", int'(u_dut.r_state), int'(StWaitEof));
        bus_d.respawn = 1'b1;
        tick();
        bus_d.respawn = 1'b0;
        check("resp_tlx", int'(bus_d.topLeftX), 100);
        check("resp_tly", int'(bus_d.topLeftY), 100);
        check("resp_state", int'(u_dut.r_state), int'(StIdle));
        check("resp_flags", {bus_d.wallHit, bus_d.frameDone}, 0);
        check("resp_yspd", u_dut.r_yspd, 20);

        // Corner spawn: both axes clamp in one update with a single wallHit.
        bus_e.startOfFrame = 1'b1;
        tick();
        tick();
        bus_e.startOfFrame = 1'b0;
        tick();
        tick();
        check("edge_xfp", u_edge.r_xpos, 36672);
        check("edge_yfp", u_edge.r_ypos, 26432);
        check("edge_xspd", u_edge.r_xspd, -40);
        check("edge_yspd", u_edge.r_yspd, -20);
        check("edge_wall", int'(bus_e.wallHit), 1);
        tick();
        check("edge_wall_clr", int'(bus_e.wallHit), 0);
        bus_e.startOfFrame = 1'b1;
        tick();
        bus_e.startOfFrame = 1'b0;
        tick();
        tick();
        check("edge2_tlx", int'(bus_e.topLeftX), 572);
        check("edge2_tly", int'(bus_e.topLeftY), 412);
        check("edge2_wall", int'(bus_e.wallHit), 0);

        // Y acceleration with saturation.
        bus_a.startOfFrame = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_a.startOfFrame = 1'b1;
            tick();
            bus_a.startOfFrame = 1'b0;
            tick();
            tick();
            check($sformatf("acc%0d_yspd", i), u_acc.r_yspd, acc_spd[i]);
            check($sformatf("acc%0d_yfp", i), u_acc.r_ypos, acc_pos[i]);
        end

        // Asynchronous reset while the position update is in flight.
        bus_d.startOfFrame = 1'b1;
        tick();
        bus_d.startOfFrame = 1'b0;
        for (int i = 0; i < 2; i++) frame_d(2'd0, 0, 0, 1'b0, 4'h0);
        check("pre_rst_tlx", int'(bus_d.topLeftX), 101);
        tick();
        bus_d.startOfFrame = 1'b1;
        tick();
        bus_d.startOfFrame = 1'b0;
        check("pre_rst_state", int'(u_dut.r_state), int'(StPosChange));
        #2 resetN = 1'b0;
        #1;
        check("midrst_state", int'(u_dut.r_state), int'(StIdle));
        check("midrst_tlx", int'(bus_d.topLeftX), 100);
        check("midrst_xfp", u_dut.r_xpos, 6400);
        check("midrst_flags", {bus_d.wallHit, bus_d.frameDone}, 0);
        @(negedge clk);
        resetN = 1'b1;
        tick();
        check("postrst_tlx", int'(bus_d.topLeftX), 100);
        check("postrst_wall", int'(bus_d.wallHit), 0);

        // Randomized frames against the reference model.
        px = 6400; py = 6400; vx = 40; vy = 20;
        in_idle = 1'b1;
        cdone = 1'b0;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus_d.respawn = 1'b1;
                tick();
                bus_d.respawn = 1'b0;
                check("rnd_resp_tlx", int'(bus_d.topLeftX), 100);
                check("rnd_resp_state", int'(u_dut.r_state), int'(StIdle));
                px = 6400; py = 6400; vx = 40; vy = 20;
                in_idle = 1'b1;
                cdone = 1'b0;
            end
            gap = int'($urandom_range(0, 3));
            for (int k = 0; k < gap; k++) begin
                col  = 1'($urandom_range(0, 3) == 0);
                code = 4'($urandom);
                bus_d.collision   = col;
                bus_d.HitEdgeCode = code;
                tick();
                if (!in_idle && !cdone && col) begin
                    model_col(code);
                    cdone = 1'b1;
                end
            end
            m  = int'($urandom_range(0, 3));
            tx = int'($urandom_range(0, 800)) - 100;
            ty = int'($urandom_range(0, 600)) - 100;
            col  = 1'($urandom_range(0, 3) == 0);
            code = 4'($urandom);
            bus_d.mode         = 2'(m);
            bus_d.targetX      = 11'(tx);
            bus_d.targetY      = 11'(ty);
            bus_d.collision    = col;
            bus_d.HitEdgeCode  = code;
            bus_d.startOfFrame = 1'b1;
            tick();
            if (in_idle) begin
                in_idle = 1'b0;
                clear_d();
                continue;
            end
            if (col && !cdone) model_col(code);
            for (int k = 0; k < 2; k++) begin
                bus_d.startOfFrame = 1'($urandom_range(0, 1));
                bus_d.collision    = 1'($urandom_range(0, 1));
                tick();
            end
            model_frame(m, tx, ty);
            check("rnd_tlx", int'(bus_d.topLeftX), tl(px));
            check("rnd_tly", int'(bus_d.topLeftY), tl(py));
            check("rnd_xspd", u_dut.r_xspd, vx);
            check("rnd_yspd", u_dut.r_yspd, vy);
            check("rnd_done", int'(bus_d.frameDone), 1);
            check("rnd_wall", int'(bus_d.wallHit), hit);
            clear_d();
            tick();
            check("rnd_pulse_clr", {bus_d.wallHit, bus_d.frameDone}, 0);
            cdone = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
